// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// ----------------------------------------------------------------------------
// Drain side of the usb2serial 512x8 synchronous FIFO. Whenever transmission is
// enabled and the FIFO reports data, one byte is popped into a holding register
// and sent on a UART line: start bit, 8 data bits LSB first, an optional parity
// bit, then one or two stop bits. Runs on the FIFO's clock.
//
// Ports
//   Clk          in   1   system clock (same clock as the FIFO push/pop side)
//   Reset_n      in   1   asynchronous active-low reset
//   Tx_En        in   1   1: may start new bytes; 0: finish current byte, stay idle
//   POP_FLAG     in   4   FIFO pop-side level, 4'h0 = empty
//   FIFO_DOUT    in   8   FIFO read data, valid the cycle after POP
//   POP          out  1   single-cycle FIFO pop strobe
//   UART_TX      out  1   serial line, idle high (registered)
//   Tx_Busy      out  1   1 whenever the state machine is not IDLE
//   Tx_Count     out  16  bytes fully transmitted since reset, wraps
//   o_dbg_state  out  3   current state encoding, for observation only
//
// FIFO handshake: POP_FLAG acts as "valid" and is looked at only in IDLE. A
// nonzero flag there (with Tx_En=1) produces exactly one POP cycle; the FIFO
// answers with FIFO_DOUT on the following cycle, which is captured in LOAD.
// There is no other acceptance condition and no retry.
// ----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Tx_En,
    input  logic [3:0]  POP_FLAG,
    input  logic [7:0]  FIFO_DOUT,
    output logic        POP,
    output logic        UART_TX,
    output logic        Tx_Busy,
    output logic [15:0] Tx_Count,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        PAR_ODD   = (PARITY_ODD != 0);
    localparam logic        PAR_EN    = (PARITY_EN != 0);

    state_t      r_state;
    logic [15:0] r_div;
    logic [2:0]  r_bit;
    logic [7:0]  r_data;
    logic        r_parity;
    logic        r_tx;
    logic        r_pop;
    logic [15:0] r_count;

    state_t      w_state_next;
    logic [15:0] w_div_next;
    logic [2:0]  w_bit_next;
    logic [15:0] w_count_next;
    logic        w_tx_next;
    logic        w_pop_next;
    logic        w_bit_end;

    assign w_bit_end = (r_div == DIV_LAST);

    // Next-state, divider, bit index and byte counter.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (Tx_En && (POP_FLAG != 4'h0)) begin
                    w_state_next = S_POP;
                end
            end
            S_POP: begin
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = S_START;
                w_div_next   = 16'd0;
                w_bit_next   = 3'd0;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_div_next   = 16'd0;
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                end else begin
                    w_div_next = r_div + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_div_next = 16'd0;
                    if (r_bit == 3'd7) begin
                        w_bit_next   = 3'd0;
                        w_state_next = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_div_next = r_div + 16'd1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_div_next   = 16'd0;
                    w_bit_next   = 3'd0;
                    w_state_next = S_STOP;
                end else begin
                    w_div_next = r_div + 16'd1;
                end
            end
            S_STOP: begin
                // r_bit counts stop bits here, so the divider never needs to
                // span STOP_BITS*CLKS_PER_BIT.
                if (w_bit_end) begin
                    w_div_next = 16'd0;
                    if (r_bit == STOP_LAST) begin
                        w_bit_next   = 3'd0;
                        w_count_next = r_count + 16'd1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_div_next = r_div + 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_div_next   = 16'd0;
                w_bit_next   = 3'd0;
            end
        endcase
    end

    // Line level and pop strobe are computed for the state being entered, so
    // the registered outputs line up cycle-for-cycle with r_state.
    always_comb begin
        w_tx_next  = 1'b1;
        w_pop_next = (w_state_next == S_POP);
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_data[w_bit_next];
            S_PARITY: w_tx_next = r_parity;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_div    <= 16'd0;
            r_bit    <= 3'd0;
            r_data   <= 8'd0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_pop    <= 1'b0;
            r_count  <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            r_pop   <= w_pop_next;
            r_count <= w_count_next;
            if (r_state == S_LOAD) begin
                r_data   <= FIFO_DOUT;
                r_parity <= (^FIFO_DOUT) ^ PAR_ODD;
            end
        end
    end

    assign POP         = r_pop;
    assign UART_TX     = r_tx;
    assign Tx_Busy     = (r_state != S_IDLE);
    assign Tx_Count    = r_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int N = 3;
  // lane 0: 4 clk/bit, no parity, 1 stop
  // lane 1: 4 clk/bit, even parity, 2 stop
  // lane 2: 5 clk/bit, odd parity, 1 stop
  localparam int CPB [N] = '{4, 4, 5};
  localparam int PE  [N] = '{0, 1, 1};
  localparam int ODD [N] = '{0, 0, 1};
  localparam int STB [N] = '{1, 2, 1};

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Tx_En;
  logic [3:0]  pop_flag  [N] = '{default: 4'h0};
  logic [7:0]  fifo_dout [N] = '{default: 8'h00};
  logic        pop       [N];
  logic        uart_tx   [N];
  logic        busy      [N];
  logic [15:0] cnt       [N];
  logic [2:0]  dbg       [N];

  logic        push_v [N] = '{default: 1'b0};
  logic [7:0]  push_d [N] = '{default: 8'h00};
  logic [7:0]  fifo_q [N][$];
  logic [7:0]  exp_q  [N][$];
  int          start_hist [N][$];
  logic [15:0] exp_cnt [N] = '{default: 16'h0};
  int          pop_cnt [N] = '{default: 0};
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  pop_tmp;

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- DUTs ----------------
  fifo_uart_tx #(.CLKS_PER_BIT(CPB[0]), .PARITY_EN(PE[0]), .PARITY_ODD(ODD[0]), .STOP_BITS(STB[0])) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .Tx_En(Tx_En), .POP_FLAG(pop_flag[0]), .FIFO_DOUT(fifo_dout[0]),
    .POP(pop[0]), .UART_TX(uart_tx[0]), .Tx_Busy(busy[0]), .Tx_Count(cnt[0]), .o_dbg_state(dbg[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB[1]), .PARITY_EN(PE[1]), .PARITY_ODD(ODD[1]), .STOP_BITS(STB[1])) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .Tx_En(Tx_En), .POP_FLAG(pop_flag[1]), .FIFO_DOUT(fifo_dout[1]),
    .POP(pop[1]), .UART_TX(uart_tx[1]), .Tx_Busy(busy[1]), .Tx_Count(cnt[1]), .o_dbg_state(dbg[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB[2]), .PARITY_EN(PE[2]), .PARITY_ODD(ODD[2]), .STOP_BITS(STB[2])) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .Tx_En(Tx_En), .POP_FLAG(pop_flag[2]), .FIFO_DOUT(fifo_dout[2]),
    .POP(pop[2]), .UART_TX(uart_tx[2]), .Tx_Busy(busy[2]), .Tx_Count(cnt[2]), .o_dbg_state(dbg[2]));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // ---------------- FIFO model (pop data registered) ----------------
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) begin
      if (pop[k] === 1'b1) begin
        check($sformatf("pop_nonempty_l%0d", k), (fifo_q[k].size() != 0), 1);
        if (fifo_q[k].size() != 0) begin
          pop_tmp = fifo_q[k].pop_front();
          fifo_dout[k] <= pop_tmp;
        end
        pop_cnt[k] <= pop_cnt[k] + 1;
      end
      if (push_v[k]) fifo_q[k].push_back(push_d[k]);
      pop_flag[k] <= (fifo_q[k].size() > 15) ? 4'hF : 4'(fifo_q[k].size());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input int k, input logic [7:0] d, input bit with_exp);
    if (with_exp) exp_q[k].push_back(d);
    push_v[k] = 1'b1;
    push_d[k] = d;
    @(negedge Clk);
    push_v[k] = 1'b0;
  endtask

  task automatic wait_pop(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (pop_cnt[k] < target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (pop_cnt[k] < target) check($sformatf("wait_pop_timeout_l%0d", k), pop_cnt[k], target);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while ((busy[k] || fifo_q[k].size() != 0) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (busy[k] || fifo_q[k].size() != 0) check($sformatf("wait_idle_timeout_l%0d", k), n, 0);
    repeat (3) @(negedge Clk);
  endtask

  // ---------------- monitor: decode each frame against exp_q ----------------
  task automatic monitor_lane(input int k);
    logic       prev;
    logic [7:0] d;
    logic       lv [12];
    int         nb;
    int         ones;
    logic       ok;
    prev = 1'b1;
    forever begin
      @(negedge Clk);
      if (prev === 1'b1 && uart_tx[k] === 1'b0) begin
        start_hist[k].push_back(cyc);
        d = 8'h00;
        if (exp_q[k].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_l%0d: got a start bit, expected no frame", k);
        end else begin
          d = exp_q[k].pop_front();
        end
        ones = $countones(d);
        nb = 0;
        lv[nb] = 1'b0; nb = nb + 1;
        for (int i = 0; i < 8; i++) begin
          lv[nb] = d[i]; nb = nb + 1;
        end
        if (PE[k] != 0) begin
          // parity bit makes the total count of ones even (or odd)
          lv[nb] = (ODD[k] != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
          nb = nb + 1;
        end
        for (int s = 0; s < STB[k]; s++) begin
          lv[nb] = 1'b1; nb = nb + 1;
        end
        for (int b = 0; b < nb; b++) begin
          ok = 1'b1;
          for (int s = 0; s < CPB[k]; s++) begin
            if (b != 0 || s != 0) @(negedge Clk);
            if (uart_tx[k] !== lv[b]) ok = 1'b0;
          end
          check($sformatf("l%0d_byte%02h_bit%0d_held_at_%0d", k, d, b, lv[b]), ok, 1);
        end
        @(negedge Clk);
        exp_cnt[k] = exp_cnt[k] + 16'd1;
        check($sformatf("tx_count_l%0d", k), cnt[k], exp_cnt[k]);
      end
      prev = uart_tx[k];
    end
  endtask

  task automatic busy_lane(input int k);
    int run;
    run = 0;
    forever begin
      @(negedge Clk);
      if (busy[k] === 1'b1) begin
        run++;
      end else begin
        if (run > 0) check($sformatf("busy_len_l%0d", k), run, CPB[k] * (9 + PE[k] + STB[k]) + 2);
        run = 0;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p0;
    int viol [N];
    int nstart;

    Reset_n = 1'b0;
    Tx_En   = 1'b0;
    repeat (3) @(negedge Clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_tx_l%0d", k), uart_tx[k], 1);
      check($sformatf("rst_pop_l%0d", k), pop[k], 0);
      check($sformatf("rst_busy_l%0d", k), busy[k], 0);
      check($sformatf("rst_count_l%0d", k), cnt[k], 0);
    end
    Reset_n = 1'b1;
    Tx_En   = 1'b1;
    @(negedge Clk);

    // reset in the middle of a data bit: line high at once, nothing counted
    push_byte(0, 8'hC3, 1'b0);
    wait_pop(0, 1, 50);
    repeat (10) @(negedge Clk);
    check("busy_before_midframe_reset", busy[0], 1);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_tx", uart_tx[0], 1);
    check("midrst_pop", pop[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_count", cnt[0], 0);
    @(negedge Clk);
    check("midrst_tx_held", uart_tx[0], 1);
    Reset_n = 1'b1;
    @(negedge Clk);

    fork
      monitor_lane(0);
      monitor_lane(1);
      monitor_lane(2);
      busy_lane(0);
      busy_lane(1);
      busy_lane(2);
    join_none

    // single byte 0x55
    p0 = pop_cnt[0];
    push_byte(0, 8'h55, 1'b1);
    wait_idle(0, 500);
    check("single_pops", pop_cnt[0] - p0, 1);
    check("single_count", cnt[0], 1);

    // back-to-back bytes
    p0 = pop_cnt[0];
    push_byte(0, 8'hA5, 1'b1);
    push_byte(0, 8'h3C, 1'b1);
    wait_idle(0, 500);
    check("b2b_pops", pop_cnt[0] - p0, 2);
    check("b2b_count", cnt[0], 3);
    nstart = start_hist[0].size();
    if (nstart >= 2)
      check("b2b_period", start_hist[0][nstart-1] - start_hist[0][nstart-2],
            CPB[0] * (9 + PE[0] + STB[0]) + 3);
    else
      check("b2b_frames_seen", nstart, 2);

    // parity / stop-bit variants on all lanes
    for (int k = 0; k < N; k++) push_byte(k, 8'h07, 1'b1);
    for (int k = 0; k < N; k++) wait_idle(k, 500);

    // empty FIFO: no pops, line idle
    for (int k = 0; k < N; k++) viol[k] = 0;
    repeat (100) begin
      @(negedge Clk);
      for (int k = 0; k < N; k++) if (pop[k] !== 1'b0 || uart_tx[k] !== 1'b1) viol[k]++;
    end
    for (int k = 0; k < N; k++) check($sformatf("empty_idle_l%0d", k), viol[k], 0);

    // random traffic with Tx_En toggling
    repeat (40) begin
      push_byte($urandom_range(0, N - 1), 8'($urandom), 1'b1);
      Tx_En = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 20)) @(negedge Clk);
    end
    Tx_En = 1'b1;
    for (int k = 0; k < N; k++) wait_idle(k, 5000);

    // Tx_En dropped mid-byte with counter preloaded to wrap
    force u_a.r_count = 16'hFFFF;
    @(negedge Clk);
    release u_a.r_count;
    exp_cnt[0] = 16'hFFFF;
    p0 = pop_cnt[0];
    push_byte(0, 8'h81, 1'b1);
    push_byte(0, 8'h42, 1'b1);
    wait_pop(0, p0 + 1, 50);
    repeat (10) @(negedge Clk);
    Tx_En = 1'b0;
    for (int n = 0; n < 200 && busy[0]; n++) @(negedge Clk);
    check("txen_drop_idle", busy[0], 0);
    repeat (60) @(negedge Clk);
    check("txen_drop_pops", pop_cnt[0] - p0, 1);
    check("txen_drop_wrap", cnt[0], 16'h0000);
    check("txen_drop_fifo_left", fifo_q[0].size(), 1);
    Tx_En = 1'b1;
    wait_idle(0, 500);
    check("txen_resume_pops", pop_cnt[0] - p0, 2);
    check("txen_resume_count", cnt[0], 16'h0001);

    for (int k = 0; k < N; k++) check($sformatf("exp_drained_l%0d", k), exp_q[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit
  initial begin
    #900000;
    $display("FAIL global_timeout: got time limit, expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
